// File: rtl/seg7_scan_mux.sv
// ============================================================================
// Module   : seg7_scan_mux
// Purpose  : Time-division scanner for NUM_DIGITS 7-segment digits sharing one
//            segment bus, with anti-ghost gap, tear-free load and LZ blanking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_mux #(
    parameter int NUM_DIGITS     = 3,
    parameter int DIV_WIDTH      = 16,
    parameter int GAP_CYCLES     = 1,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [DIV_WIDTH-1:0]    div_max,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_start
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [GAP_W-1:0]      GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [6:0]            SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] SEL_OFF  = {NUM_DIGITS{SEL_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] SEL_ONE  = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    logic [1:0]              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DIV_WIDTH-1:0]    presc_q, presc_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic                    first_q, first_d;
    logic                    pend_q, pend_d;
    logic [4*NUM_DIGITS-1:0] pend_bcd_q, pend_bcd_d, disp_bcd_q, disp_bcd_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d, fs_q, fs_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic                    w_commit;
    logic                    w_upper_zero;
    logic [3:0]              w_nib;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'h0:    seg_decode = 7'h3F;
            4'h1:    seg_decode = 7'h06;
            4'h2:    seg_decode = 7'h5B;
            4'h3:    seg_decode = 7'h4F;
            4'h4:    seg_decode = 7'h66;
            4'h5:    seg_decode = 7'h6D;
            4'h6:    seg_decode = 7'h7D;
            4'h7:    seg_decode = 7'h07;
            4'h8:    seg_decode = 7'h7F;
            4'h9:    seg_decode = 7'h6F;
            4'hA:    seg_decode = 7'h40;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_OFF;
            idx_q      <= '0;
            presc_q    <= '0;
            gap_q      <= '0;
            first_q    <= 1'b0;
            pend_q     <= 1'b0;
            pend_bcd_q <= '0;
            pend_dp_q  <= '0;
            disp_bcd_q <= '0;
            disp_dp_q  <= '0;
            seg_q      <= SEG_OFF;
            dp_q       <= SEG_ACTIVE_LOW;
            sel_q      <= SEL_OFF;
            fs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            presc_q    <= presc_d;
            gap_q      <= gap_d;
            first_q    <= first_d;
            pend_q     <= pend_d;
            pend_bcd_q <= pend_bcd_d;
            pend_dp_q  <= pend_dp_d;
            disp_bcd_q <= disp_bcd_d;
            disp_dp_q  <= disp_dp_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            sel_q      <= sel_d;
            fs_q       <= fs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        presc_d = presc_q;
        gap_d   = gap_q;
        case (state_q)
            ST_OFF: begin
                if (enable) begin
                    state_d = ST_DRIVE;
                    idx_d   = '0;
                    presc_d = '0;
                end
            end
            ST_DRIVE: begin
                if (presc_q == div_max) begin
                    presc_d = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d = ST_GAP;
                        gap_d   = '0;
                    end else begin
                        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_DRIVE;
                    presc_d = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_OFF;
        endcase
        if (!enable) begin
            state_d = ST_OFF;
            idx_d   = '0;
            presc_d = '0;
            gap_d   = '0;
        end

        // A frame begins on the edge that lands on DRIVE/digit 0 from anywhere else
        first_d  = (state_d == ST_DRIVE) && (idx_d == '0) &&
                   !((state_q == ST_DRIVE) && (idx_q == '0));
        w_commit = pend_q && ((state_q == ST_OFF) || first_d);

        disp_bcd_d = w_commit ? pend_bcd_q : disp_bcd_q;
        disp_dp_d  = w_commit ? pend_dp_q  : disp_dp_q;
        pend_bcd_d = load ? bcd_in : pend_bcd_q;
        pend_dp_d  = load ? dp_in  : pend_dp_q;
        pend_d     = load | (pend_q & ~w_commit);
    end

    always_comb begin
        w_nib        = disp_bcd_q[4*idx_q +: 4];
        w_upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((i >= int'(idx_q)) && (disp_bcd_q[4*i +: 4] != 4'd0)) begin
                w_upper_zero = 1'b0;
            end
        end

        seg_d = 7'h00;
        dp_d  = 1'b0;
        sel_d = '0;
        fs_d  = 1'b0;
        if (state_q == ST_DRIVE) begin
            sel_d = SEL_ONE << idx_q;
            seg_d = (blank_lz && (idx_q != '0) && w_upper_zero) ? 7'h00 : seg_decode(w_nib);
            dp_d  = disp_dp_q[idx_q];
            fs_d  = first_q;
        end
        seg_d = seg_d ^ SEG_OFF;
        dp_d  = dp_d ^ SEG_ACTIVE_LOW;
        sel_d = sel_d ^ SEL_OFF;
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign digit_sel   = sel_q;
    assign frame_start = fs_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_mux.sv
// ============================================================================
// Module   : tb_seg7_scan_mux
// Purpose  : Self-checking bench for seg7_scan_mux (active-high and
//            active-low pin variants driven from the same stimulus).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_mux;

    localparam int N  = 3;
    localparam int DW = 16;
    localparam int G  = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          load = 1'b0;
    logic          blank_lz = 1'b0;
    logic [DW-1:0] div_max = 16'd3;
    logic [11:0]   bcd_in = 12'h000;
    logic [2:0]    dp_in = 3'b000;

    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b, fs_a, fs_b;
    logic [2:0] sel_a, sel_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_scan_mux #(.NUM_DIGITS(N), .DIV_WIDTH(DW), .GAP_CYCLES(G),
                    .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b0)) u_hi (
        .clk(clk), .rst_n(rst_n), .enable(enable), .div_max(div_max),
        .load(load), .bcd_in(bcd_in), .dp_in(dp_in), .blank_lz(blank_lz),
        .seg(seg_a), .dp(dp_a), .digit_sel(sel_a), .frame_start(fs_a));

    seg7_scan_mux #(.NUM_DIGITS(N), .DIV_WIDTH(DW), .GAP_CYCLES(G),
                    .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)) u_lo (
        .clk(clk), .rst_n(rst_n), .enable(enable), .div_max(div_max),
        .load(load), .bcd_in(bcd_in), .dp_in(dp_in), .blank_lz(blank_lz),
        .seg(seg_b), .dp(dp_b), .digit_sel(sel_b), .frame_start(fs_b));

    // ---------------- behavioural model: time since scan start ----------------
    logic [11:0] m_disp, m_pbcd;
    logic [2:0]  m_ddp, m_pdp;
    bit          m_pend, m_on, m_valid;
    int          m_t;
    logic [6:0]  e_seg;
    logic        e_dp, e_fs;
    logic [2:0]  e_sel;

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        logic [6:0] tbl [16];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        return tbl[v];
    endfunction

    always @(posedge clk) begin
        int         slot_len, frame_len, pos, d;
        bit         was_on, commit;
        logic [3:0] nib;
        slot_len  = int'(div_max) + 1 + G;
        frame_len = slot_len * N;
        if (!rst_n) begin
            m_disp = '0; m_pbcd = '0; m_ddp = '0; m_pdp = '0;
            m_pend = 1'b0; m_on = 1'b0; m_t = 0; m_valid = 1'b1;
            e_seg = '0; e_dp = 1'b0; e_sel = '0; e_fs = 1'b0;
        end else begin
            e_seg = '0; e_dp = 1'b0; e_sel = '0; e_fs = 1'b0;
            if (m_on) begin
                pos = m_t % slot_len;
                d   = (m_t / slot_len) % N;
                if (pos <= int'(div_max)) begin
                    nib   = 4'(m_disp >> (4 * d));
                    e_sel = 3'(1 << d);
                    e_seg = (blank_lz && d > 0 && (m_disp >> (4 * d)) == 12'h000) ? 7'h00 : ref_seg(nib);
                    e_dp  = m_ddp[d];
                    e_fs  = (m_t % frame_len) == 0;
                end
            end
            was_on = m_on;
            if (!enable) begin
                m_on = 1'b0; m_t = 0;
            end else if (!m_on) begin
                m_on = 1'b1; m_t = 0;
            end else begin
                m_t++;
            end
            commit = m_pend && (!was_on || (m_on && (m_t % frame_len) == 0));
            if (commit) begin
                m_disp = m_pbcd; m_ddp = m_pdp;
            end
            if (load) begin
                m_pend = 1'b1; m_pbcd = bcd_in; m_pdp = dp_in;
            end else if (commit) begin
                m_pend = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if ({seg_a, dp_a, sel_a, fs_a} !== {e_seg, e_dp, e_sel, e_fs}) begin
                errors++;
                $display("FAIL model_hi t=%0t: got seg=%h dp=%b sel=%b fs=%b, want seg=%h dp=%b sel=%b fs=%b",
                         $time, seg_a, dp_a, sel_a, fs_a, e_seg, e_dp, e_sel, e_fs);
            end
            checks++;
            if ({seg_b, dp_b, sel_b, fs_b} !== {~e_seg, ~e_dp, ~e_sel, e_fs}) begin
                errors++;
                $display("FAIL model_lo t=%0t: got seg=%h dp=%b sel=%b fs=%b, want seg=%h dp=%b sel=%b fs=%b",
                         $time, seg_b, dp_b, sel_b, fs_b, ~e_seg, ~e_dp, ~e_sel, e_fs);
            end
        end
    end

    // ---------------- directed stimulus and literal checks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic wait_sel(input logic [2:0] s, input bit need_fs);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (sel_a == s && (!need_fs || fs_a)) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_sel: got sel=%b want sel=%b fs=%b within 200 cycles", sel_a, s, need_fs);
        end
    endtask

    task automatic load_val(input logic [11:0] v, input logic [2:0] d);
        bcd_in = v; dp_in = d; load = 1'b1;
        tick(1);
        load = 1'b0;
    endtask

    logic [6:0] frame_segs [3];
    int         kk;

    initial begin
        frame_segs = '{7'h4F, 7'h5B, 7'h06};

        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("reset_seg_hi", 32'(seg_a), 32'h00);
        chk("reset_sel_hi", 32'(sel_a), 32'h0);
        chk("reset_dpfs_hi", 32'({dp_a, fs_a}), 32'h0);
        chk("reset_seg_lo", 32'(seg_b), 32'h7F);
        chk("reset_seldp_lo", 32'({sel_b, dp_b}), 32'hF);

        // scan timing: digits 2,1,0 = 1,2,3
        load_val(12'h123, 3'b000);
        tick(1);
        enable = 1'b1;
        tick(1);
        for (int k = 0; k < 16; k++) begin
            tick(1);
            kk = k % 15;
            chk("scan_sel", 32'(sel_a), (kk % 5 < 4) ? 32'(1 << (kk / 5)) : 32'h0);
            chk("scan_seg", 32'(seg_a), (kk % 5 < 4) ? 32'(frame_segs[kk / 5]) : 32'h0);
            chk("scan_fs", 32'(fs_a), (kk == 0) ? 32'h1 : 32'h0);
        end

        // tear-free load in the middle of digit 1
        tick(6);
        chk("tear_in_digit1", 32'(sel_a), 32'h2);
        load_val(12'h777, 3'b000);
        wait_sel(3'b100, 1'b0);
        chk("tear_old_d2", 32'(seg_a), 32'h06);
        wait_sel(3'b001, 1'b1);
        chk("tear_new_d0", 32'(seg_a), 32'h07);
        wait_sel(3'b010, 1'b0);
        chk("tear_new_d1", 32'(seg_a), 32'h07);
        wait_sel(3'b100, 1'b0);
        chk("tear_new_d2", 32'(seg_a), 32'h07);

        // leading-zero blanking
        blank_lz = 1'b1;
        load_val(12'h005, 3'b000);
        wait_sel(3'b001, 1'b1);
        chk("lz5_d0", 32'(seg_a), 32'h6D);
        wait_sel(3'b010, 1'b0);
        chk("lz5_d1", 32'(seg_a), 32'h00);
        wait_sel(3'b100, 1'b0);
        chk("lz5_d2", 32'(seg_a), 32'h00);
        load_val(12'h000, 3'b000);
        wait_sel(3'b001, 1'b1);
        chk("lz0_d0", 32'(seg_a), 32'h3F);
        wait_sel(3'b010, 1'b0);
        chk("lz0_d1", 32'(seg_a), 32'h00);
        wait_sel(3'b100, 1'b0);
        chk("lz0_d2", 32'(seg_a), 32'h00);
        blank_lz = 1'b0;
        load_val(12'h005, 3'b000);
        wait_sel(3'b001, 1'b1);
        chk("nolz_d0", 32'(seg_a), 32'h6D);
        wait_sel(3'b010, 1'b0);
        chk("nolz_d1", 32'(seg_a), 32'h3F);
        wait_sel(3'b100, 1'b0);
        chk("nolz_d2", 32'(seg_a), 32'h3F);

        // dash code with decimal point, both polarities
        load_val(12'h00A, 3'b001);
        wait_sel(3'b001, 1'b1);
        chk("dash_seg_hi", 32'(seg_a), 32'h40);
        chk("dash_dp_hi", 32'(dp_a), 32'h1);
        chk("dash_seg_lo", 32'(seg_b), 32'h3F);
        chk("dash_dp_lo", 32'(dp_b), 32'h0);
        chk("dash_sel_lo", 32'(sel_b), 32'h6);
        tick(4);
        chk("gap_seg_lo", 32'(seg_b), 32'h7F);
        chk("gap_dp_lo", 32'(dp_b), 32'h1);
        chk("gap_sel_lo", 32'(sel_b), 32'h7);

        // enable drop mid digit 1, then re-enable
        wait_sel(3'b010, 1'b0);
        enable = 1'b0;
        tick(2);
        chk("drop_sel", 32'(sel_a), 32'h0);
        chk("drop_seg", 32'(seg_a), 32'h00);
        enable = 1'b1;
        tick(2);
        chk("reen_sel", 32'(sel_a), 32'h1);
        chk("reen_fs", 32'(fs_a), 32'h1);

        // reset discards pending data
        load_val(12'h999, 3'b111);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        wait_sel(3'b001, 1'b1);
        chk("rst_pend_d0", 32'(seg_a), 32'h3F);
        chk("rst_pend_dp", 32'(dp_a), 32'h0);
        wait_sel(3'b010, 1'b0);
        chk("rst_pend_d1", 32'(seg_a), 32'h3F);

        // single-cycle dwell
        enable = 1'b0;
        tick(2);
        div_max = '0;
        tick(1);
        enable = 1'b1;
        tick(1);
        for (int k = 0; k < 7; k++) begin
            tick(1);
            kk = k % 6;
            chk("dwell1_sel", 32'(sel_a), (kk % 2 == 0) ? 32'(1 << (kk / 2)) : 32'h0);
            chk("dwell1_fs", 32'(fs_a), (kk == 0) ? 32'h1 : 32'h0);
        end

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
